// File: rtl/somador_serial.sv
// Serial signed adder/subtractor: processes PASSO bits per clock, LSB slice first,
// and publishes result and flags together when the last slice is done.
module somador_serial #(
    parameter int LARGURA = 8,
    parameter int PASSO   = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Inicio,
    input  logic               Modo,
    input  logic [LARGURA-1:0] Entrada1,
    input  logic [LARGURA-1:0] Entrada2,
    output logic [LARGURA-1:0] Resultado,
    output logic               Carry,
    output logic               Overflow,
    output logic               Zero,
    output logic               Ocupado,
    output logic               Pronto
);

    localparam int K  = LARGURA / PASSO;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(K - 1);

    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

    estado_t            estado;
    logic [LARGURA-1:0] a;
    logic [LARGURA-1:0] b;
    logic [LARGURA-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               cin;

    logic [PASSO:0]     soma;
    logic               cout;
    logic               cmsb;
    logic [LARGURA-1:0] res_nxt;

    // Operands shift right each slice; the partial sum enters acc from the top,
    // so after K slices acc holds the full word in place.
    always_comb begin
        soma    = {1'b0, a[PASSO-1:0]} + {1'b0, b[PASSO-1:0]} + {{PASSO{1'b0}}, cin};
        cout    = soma[PASSO];
        cmsb    = soma[PASSO-1] ^ a[PASSO-1] ^ b[PASSO-1];
        res_nxt = LARGURA'({soma[PASSO-1:0], acc} >> PASSO);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado    <= OCIOSO;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            cnt       <= '0;
            cin       <= 1'b0;
            Resultado <= '0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
            Ocupado   <= 1'b0;
            Pronto    <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    Pronto <= 1'b0;
                    if (Inicio) begin
                        a       <= Entrada1;
                        b       <= Modo ? ~Entrada2 : Entrada2;
                        cin     <= Modo;
                        acc     <= '0;
                        cnt     <= '0;
                        Ocupado <= 1'b1;
                        estado  <= CALCULA;
                    end
                end
                CALCULA: begin
                    a   <= a >> PASSO;
                    b   <= b >> PASSO;
                    cin <= cout;
                    acc <= res_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == ULTIMO) begin
                        Resultado <= res_nxt;
                        Carry     <= cout;
                        Overflow  <= cmsb ^ cout;
                        Zero      <= (res_nxt == '0);
                        Pronto    <= 1'b1;
                        estado    <= FIM;
                    end
                end
                FIM: begin
                    Pronto  <= 1'b0;
                    Ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: two instances (PASSO=1 and PASSO=4) checked every cycle
// against an arithmetic model, plus hand-computed expectations per directed vector.
module tb_somador_serial;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Inicio = 1'b0;
    logic       Modo = 1'b0;
    logic [7:0] Entrada1 = '0;
    logic [7:0] Entrada2 = '0;

    logic [7:0] res [2];
    logic       car [2];
    logic       ovf [2];
    logic       zer [2];
    logic       ocu [2];
    logic       pro [2];

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    somador_serial #(.LARGURA(8), .PASSO(1)) d1 (
        .Clock(Clock), .Reset(Reset), .Inicio(Inicio), .Modo(Modo),
        .Entrada1(Entrada1), .Entrada2(Entrada2),
        .Resultado(res[0]), .Carry(car[0]), .Overflow(ovf[0]), .Zero(zer[0]),
        .Ocupado(ocu[0]), .Pronto(pro[0])
    );

    somador_serial #(.LARGURA(8), .PASSO(4)) d4 (
        .Clock(Clock), .Reset(Reset), .Inicio(Inicio), .Modo(Modo),
        .Entrada1(Entrada1), .Entrada2(Entrada2),
        .Resultado(res[1]), .Carry(car[1]), .Overflow(ovf[1]), .Zero(zer[1]),
        .Ocupado(ocu[1]), .Pronto(pro[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {carry, overflow, zero, result} from plain integer arithmetic.
    function automatic logic [10:0] calc(input logic [7:0] x, input logic [7:0] y, input logic m);
        int sx, sy, ux, uy, r;
        logic c, v, z;
        logic [7:0] r8;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        r  = m ? sx - sy : sx + sy;
        r8 = r[7:0];
        v  = (r > 127) || (r < -128);
        c  = m ? (ux >= uy) : (ux + uy > 255);
        z  = (r8 == 8'd0);
        return {c, v, z, r8};
    endfunction

    // Model: idle / busy-with-cycle-count / done, per instance.
    int         mph [2];
    int         mcnt [2];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic       pm [2];
    logic [7:0] mres [2];
    logic       mc [2], mv [2], mz [2], mocc [2], mpr [2];
    logic       mvalid = 1'b0;

    always @(posedge Clock) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                mph[i] <= 0; mcnt[i] <= 0; mres[i] <= '0;
                mc[i] <= 1'b0; mv[i] <= 1'b0; mz[i] <= 1'b1;
                mocc[i] <= 1'b0; mpr[i] <= 1'b0;
            end else if (mph[i] == 0) begin
                mpr[i] <= 1'b0;
                if (Inicio) begin
                    mph[i] <= 1; mcnt[i] <= 1; mocc[i] <= 1'b1;
                    pa[i] <= Entrada1; pb[i] <= Entrada2; pm[i] <= Modo;
                end
            end else if (mph[i] == 1) begin
                if (mcnt[i] == ((i == 0) ? 8 : 2)) begin
                    {mc[i], mv[i], mz[i], mres[i]} <= calc(pa[i], pb[i], pm[i]);
                    mpr[i] <= 1'b1;
                    mph[i] <= 2;
                end else begin
                    mcnt[i] <= mcnt[i] + 1;
                end
            end else begin
                mpr[i] <= 1'b0; mocc[i] <= 1'b0; mph[i] <= 0;
            end
        end
        if (Reset) mvalid <= 1'b1;
    end

    always @(negedge Clock) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_res[%0d]", i), {24'd0, res[i]}, {24'd0, mres[i]});
                chk($sformatf("model_flags[%0d]", i),
                    {26'd0, car[i], ovf[i], zer[i], ocu[i], pro[i]},
                    {26'd0, mc[i], mv[i], mz[i], mocc[i], mpr[i]});
            end
        end
    end

    // Runs one operation; extra=1 re-pulses Inicio so it is sampled at edge t+3.
    task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic m, input bit extra,
                          input logic [7:0] er, input logic ec, input logic ev, input logic ez);
        int occ, prc, lat, prc4, lat4;
        logic [7:0] r4;
        logic v4;
        occ = 0; prc = 0; lat = -1; prc4 = 0; lat4 = -1; r4 = '0; v4 = 1'b0;
        @(negedge Clock);
        Entrada1 = x; Entrada2 = y; Modo = m; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        Entrada1 = ~x; Entrada2 = ~y;
        for (int n = 0; n < 30; n++) begin
            if (ocu[0]) occ++;
            if (pro[0]) begin prc++; lat = n; end
            if (pro[1]) begin prc4++; lat4 = n; r4 = res[1]; v4 = ovf[1]; end
            if (extra && n == 2) Inicio = 1'b1;
            if (n == 3) Inicio = 1'b0;
            @(negedge Clock);
        end
        chk({name, "_res"}, {24'd0, res[0]}, {24'd0, er});
        chk({name, "_cvz"}, {29'd0, car[0], ovf[0], zer[0]}, {29'd0, ec, ev, ez});
        chk({name, "_latency"}, lat, 8);
        chk({name, "_pronto_count"}, prc, 1);
        chk({name, "_ocupado_cycles"}, occ, 9);
        chk({name, "_p4_latency"}, lat4, 2);
        chk({name, "_p4_pronto_count"}, prc4, 1);
        chk({name, "_p4_res"}, {23'd0, v4, r4}, {23'd0, ev, er});
    endtask

    initial begin
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_res[%0d]", i), {24'd0, res[i]}, 32'd0);
            chk($sformatf("reset_flags[%0d]", i),
                {26'd0, car[i], ovf[i], zer[i], ocu[i], pro[i]}, 32'b00100);
        end
        Reset = 1'b0;

        run_op("add_5_3",     8'd5,   8'd3,   1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("add_127_1",   8'd127, 8'd1,   1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_m1_1",    8'hFF,  8'd1,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_5_5",     8'd5,   8'd5,   1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_3_5",     8'd3,   8'd5,   1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_100_m28", 8'd100, 8'hE4,  1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_m128_1",  8'h80,  8'd1,   1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Abort a running add with reset sampled at edge t+4.
        begin
            int prc;
            prc = 0;
            @(negedge Clock);
            Entrada1 = 8'd9; Entrada2 = 8'd9; Modo = 1'b0; Inicio = 1'b1;
            @(negedge Clock);
            Inicio = 1'b0;
            repeat (3) @(negedge Clock);
            Reset = 1'b1;
            @(negedge Clock);
            Reset = 1'b0;
            chk("abort_ocupado", {31'd0, ocu[0]}, 32'd0);
            chk("abort_res", {24'd0, res[0]}, 32'd0);
            chk("abort_zero", {31'd0, zer[0]}, 32'd1);
            for (int n = 0; n < 12; n++) begin
                if (pro[0]) prc++;
                @(negedge Clock);
            end
            chk("abort_no_pronto", prc, 0);
        end
        run_op("add_2_2", 8'd2, 8'd2, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
